// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multicycle MIPS control unit
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_BAD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op and funct to the 3-bit ALU control code
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_control,
  output logic        funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: begin
            alu_control   = ALU_BAD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS Moore control FSM; MIPS_CTRL_BNE_EN adds BNE
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    pc_write, branch_eq, branch_ne;
  logic    ir_write_s, mem_write_s, reg_write_s;
  logic    op_illegal, funct_illegal, illegal_next;

  alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_next;
      illegal_op <= illegal_next;
    end
  end

  always_comb begin
    state_next  = S_FETCH;
    iord        = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write_s = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = ALUOP_ADD;
    pc_src      = 2'b00;
    pc_write    = 1'b0;
    branch_eq   = 1'b0;
    branch_ne   = 1'b0;
    op_illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_s = 1'b1;
        pc_write   = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut while the opcode is examined
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_next = S_BNE;
`endif
          default:      op_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_s = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch_eq = 1'b1;
      end
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch_ne = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign illegal_next = op_illegal | ((state == S_EXECUTE) & funct_illegal);

  // Reset squashes every architectural write so an aborted instruction leaves no trace
  assign ir_write  = ir_write_s  & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign pc_en     = ~reset & (pc_write | (branch_eq & zero) | (branch_ne & ~zero));
  assign state_dbg = STATE_W'(state);

endmodule
